aes_input_stage: RTL and testbench

Ingress stage of the AES controller. It accepts a packet of 32-bit bus words and captures the first word as the command. It packs the remaining words into 128-bit blocks and queues them in a first-word-fall-through FIFO. The AES processing FSM pops the queue one block at a time (key, optional IV, then data blocks).

---
 rtl/aes_input_stage_pkg.sv | 52 +++++
 rtl/aes_input_stage_in_fifo.sv | 65 ++++++
 rtl/aes_input_stage.sv | 139 +++++++++++++
 tb/tb_aes_input_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_input_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_input_stage_pkg                                              |
// | Shared AES sizes, ingest FSM states, command decode, clogb2.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package aes_input_stage_pkg;

    localparam int CMD_BITS = 32;
    localparam int BLK_S    = 128;
    localparam int KEY_S    = 256;
    localparam int IV_BITS  = 128;

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_size_t;

    // Command layout: [0] decrypt, [1] chained mode (IV present), [5:4] key size.
    function automatic key_size_t cmd_key_size(input logic [1:0] ks_bits);
        return key_size_t'(ks_bits);
    endfunction

    function automatic logic cmd_is_decrypt(input logic dir_bit);
        return dir_bit;
    endfunction

    function automatic logic cmd_has_iv(input logic mode_bit);
        return mode_bit;
    endfunction

    function automatic int clogb2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_input_stage_in_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_in_fifo                                                      |
// | Synchronous first-word-fall-through FIFO, valid/ready pop.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module aes_in_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int SIZE       = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop_ready,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_valid,
    output logic                  o_empty,
    output logic                  o_full
);

    logic [DATA_WIDTH-1:0] r_mem [SIZE];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == (ADDR_WIDTH+1)'(SIZE));
    assign o_empty = (r_count == '0);
    assign o_valid = ~o_empty;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop_ready & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap at SIZE so non-power-of-two depths work too.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == ADDR_WIDTH'(SIZE-1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == ADDR_WIDTH'(SIZE-1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes_input_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_input_stage                                                  |
// | Captures the command word, packs 32-bit words into 128-bit       |
// | blocks and queues them. AES_IN_PARTIAL_PAD_EN: zero-pad and      |
// | push a partial trailing block instead of discarding it.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module aes_input_stage
    import aes_input_stage_pkg::*;
#(
    parameter int BUS_DATA_WIDTH  = 32,
    parameter int FIFO_DATA_WIDTH = 128,
    parameter int FIFO_SIZE       = 256,
    parameter int FIFO_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bus_data_wren,
    input  logic                       bus_tlast,
    input  logic [BUS_DATA_WIDTH-1:0]  bus_data,
    output logic                       in_fifo_read_tvalid,
    input  logic                       in_fifo_read_tready,
    output logic [FIFO_DATA_WIDTH-1:0] in_fifo_rdata,
    output logic                       in_fifo_empty,
    output logic                       controller_in_done,
    output logic                       controller_in_busy,
    output logic [CMD_BITS-1:0]        aes_cmd
);

    localparam int WORDS = FIFO_DATA_WIDTH / BUS_DATA_WIDTH;

    in_state_t                  r_state;
    in_state_t                  w_state_nxt;
    logic [1:0]                 r_cnt;
    logic [1:0]                 w_cnt_nxt;
    logic [FIFO_DATA_WIDTH-1:0] r_blk;
    logic [FIFO_DATA_WIDTH-1:0] w_blk_nxt;
    logic [FIFO_DATA_WIDTH-1:0] w_asm;
    logic [CMD_BITS-1:0]        r_cmd;
    logic [CMD_BITS-1:0]        w_cmd_nxt;
    logic                       r_done;
    logic                       w_done_nxt;
    logic                       w_push;
    logic                       w_accept;
    logic                       w_full;

    assign controller_in_busy = r_done | w_full;
    assign controller_in_done = r_done;
    assign aes_cmd            = r_cmd;
    assign w_accept           = bus_data_wren & ~controller_in_busy;

    // Block as it would look with the current word in slot r_cnt; later slots read zero.
    always_comb begin
        w_asm = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (i == int'(r_cnt)) begin
                w_asm[FIFO_DATA_WIDTH-1-BUS_DATA_WIDTH*i -: BUS_DATA_WIDTH] = bus_data;
            end else if (i < int'(r_cnt)) begin
                w_asm[FIFO_DATA_WIDTH-1-BUS_DATA_WIDTH*i -: BUS_DATA_WIDTH] =
                    r_blk[FIFO_DATA_WIDTH-1-BUS_DATA_WIDTH*i -: BUS_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CMD;
            r_cnt   <= '0;
            r_blk   <= '0;
            r_cmd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_blk   <= w_blk_nxt;
            r_cmd   <= w_cmd_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_blk_nxt   = r_blk;
        w_cmd_nxt   = r_cmd;
        w_done_nxt  = r_done;
        w_push      = 1'b0;
        // done & empty overlap for one cycle: the consumer's restart cue.
        if (r_done && in_fifo_empty) begin
            w_done_nxt = 1'b0;
        end
        if (w_accept) begin
            case (r_state)
                ST_CMD: begin
                    w_cmd_nxt = bus_data[CMD_BITS-1:0];
                    if (bus_tlast) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                default: begin
                    w_blk_nxt = w_asm;
                    w_cnt_nxt = r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        w_push = 1'b1;
                    end
                    if (bus_tlast) begin
                        w_state_nxt = ST_CMD;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
`ifdef AES_IN_PARTIAL_PAD_EN
                        w_push      = 1'b1;
`endif
                    end
                end
            endcase
        end
    end

    aes_in_fifo #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .SIZE       (FIFO_SIZE),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_wdata     (w_asm),
        .i_pop_ready (in_fifo_read_tready),
        .o_rdata     (in_fifo_rdata),
        .o_valid     (in_fifo_read_tvalid),
        .o_empty     (in_fifo_empty),
        .o_full      (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_aes_input_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_aes_input_stage                                               |
// | Randomized packets against a packet-level block model.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_aes_input_stage;

    logic         clk;
    logic         reset;
    logic         wren;
    logic         tlast;
    logic [31:0]  bdata;
    logic         tvalid;
    logic         tready;
    logic [127:0] rdata;
    logic         empty;
    logic         done;
    logic         busy;
    logic [31:0]  cmd;

    int           n_checks;
    int           n_errors;
    logic [127:0] exp_q [$];
    logic [31:0]  pkt_q [$];
    logic [31:0]  exp_cmd;

    aes_input_stage dut (
        .clk                 (clk),
        .reset               (reset),
        .bus_data_wren       (wren),
        .bus_tlast           (tlast),
        .bus_data            (bdata),
        .in_fifo_read_tvalid (tvalid),
        .in_fifo_read_tready (tready),
        .in_fifo_rdata       (rdata),
        .in_fifo_empty       (empty),
        .controller_in_done  (done),
        .controller_in_busy  (busy),
        .aes_cmd             (cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the word's clock edge.
    task automatic send_word(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            chk_eq("busy_timeout", busy, 0);
            return;
        end
        wren  = 1'b1;
        bdata = d;
        tlast = last;
        @(negedge clk);
        wren  = 1'b0;
        tlast = 1'b0;
    endtask

    // Sends pkt_q and appends the blocks the packet should yield to exp_q.
    task automatic send_pkt(input bit with_last);
        int           nd;
        logic [127:0] blk;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_word(pkt_q[i], with_last && (i == pkt_q.size() - 1));
        end
        exp_cmd = pkt_q[0];
        nd = pkt_q.size() - 1;
        for (int b = 0; 4 * b < nd; b++) begin
            blk = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * b + k < nd) blk = blk | ({96'd0, pkt_q[1 + 4 * b + k]} << (96 - 32 * k));
            end
            if (4 * b + 4 <= nd) exp_q.push_back(blk);
`ifdef AES_IN_PARTIAL_PAD_EN
            else if (with_last) exp_q.push_back(blk);
`endif
        end
    endtask

    task automatic post_pkt_checks();
        chk_eq("aes_cmd", cmd, exp_cmd);
        chk_eq("done_after_tlast", done, 1);
        chk_eq("busy_after_tlast", busy, 1);
        chk_eq("empty_vs_model", empty, exp_q.size() == 0);
    endtask

    task automatic drain();
        int de;
        int t;
        de = 0;
        t  = 0;
        while ((exp_q.size() > 0 || done) && t < 3000) begin
            tready = ($urandom_range(0, 3) != 0);
            if (done && empty) de++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) chk_eq("extra_entry", tvalid, 0);
                else chk_eq("rdata", rdata, exp_q.pop_front());
            end
            @(negedge clk);
            t++;
        end
        tready = 1'b0;
        chk_eq("missing_entries", exp_q.size(), 0);
        chk_eq("done_empty_cycles", de, 1);
        chk_eq("busy_after_drain", busy, 0);
        chk_eq("empty_after_drain", empty, 1);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] tw [4];
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        wren  = 1'b0;
        tlast = 1'b0;
        bdata = '0;
        tready = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("rst_empty", empty, 1);
        chk_eq("rst_tvalid", tvalid, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_cmd", cmd, 0);
        reset = 1'b0;
        @(negedge clk);

        // Known-answer packet.
        pkt_q = '{32'h0000_0021, 32'h0001_0203, 32'h0405_0607, 32'h0809_0A0B, 32'h0C0D_0E0F};
        send_pkt(1);
        post_pkt_checks();
        chk_eq("kat_cmd", cmd, 32'h21);
        chk_eq("kat_entry", rdata, 128'h000102030405060708090A0B0C0D0E0F);
        drain();

        // Partial trailing block: cmd + 6 words.
        pkt_q = '{32'h0000_0005, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                  32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
        send_pkt(1);
`ifdef AES_IN_PARTIAL_PAD_EN
        chk_eq("pad_model_entries", exp_q.size(), 2);
`else
        chk_eq("nopad_model_entries", exp_q.size(), 1);
`endif
        post_pkt_checks();
        drain();

        // Random back-to-back packets.
        for (int p = 0; p < 14; p++) begin
            pkt_q.delete();
            for (int i = 0; i < $urandom_range(1, 14); i++) pkt_q.push_back($urandom);
            send_pkt(1);
            post_pkt_checks();
            drain();
        end

        // Fill the FIFO completely without tlast.
        pkt_q.delete();
        pkt_q.push_back($urandom);
        for (int i = 0; i < 4 * 256; i++) pkt_q.push_back($urandom);
        send_pkt(0);
        chk_eq("full_busy", busy, 1);
        chk_eq("full_done", done, 0);
        chk_eq("full_tvalid", tvalid, 1);
        wren  = 1'b1;
        tlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bdata = 32'hDEAD_0000 + i;
            @(negedge clk);
        end
        wren  = 1'b0;
        tlast = 1'b0;
        chk_eq("dropped_tlast_done", done, 0);
        tready = 1'b1;
        chk_eq("full_pop_rdata", rdata, exp_q.pop_front());
        @(negedge clk);
        tready = 1'b0;
        chk_eq("busy_after_pop", busy, 0);
        for (int i = 0; i < 4; i++) tw[i] = $urandom;
        for (int i = 0; i < 4; i++) send_word(tw[i], i == 3);
        exp_q.push_back({tw[0], tw[1], tw[2], tw[3]});
        post_pkt_checks();
        drain();

        // Reset mid-packet.
        pkt_q = '{32'hA5A5_0001, 32'hBEEF_0001, 32'hBEEF_0002};
        send_pkt(0);
        reset = 1'b1;
        #1;
        chk_eq("midrst_empty", empty, 1);
        chk_eq("midrst_done", done, 0);
        chk_eq("midrst_cmd", cmd, 0);
        chk_eq("midrst_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pkt_q = '{32'h0000_0042, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
        send_pkt(1);
        post_pkt_checks();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
